// File: rtl/dmem_demux12.sv
// Registered 1-to-2 data-memory request demultiplexer (RAM = target 0, MMIO = target 1).
// Optional target timeout is enabled by defining DMEM_DEMUX_TIMEOUT_EN.
module dmem_demux12 #(
    parameter int         DW             = 32,
    parameter int         AW             = 32,
    parameter logic [3:0] MMIO_NIBBLE    = 4'h1,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    // initiator side
    input  logic            m_req,
    input  logic            m_we,
    input  logic [AW-1:0]   m_addr,
    input  logic [DW-1:0]   m_wdata,
    input  logic [DW/8-1:0] m_be,
    output logic            m_gnt,
    output logic            m_rvalid,
    output logic [DW-1:0]   m_rdata,
    output logic            m_err,
    // target side
    output logic            s0_req,
    output logic            s1_req,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_be,
    input  logic            s0_gnt,
    input  logic            s1_gnt,
    input  logic            s0_rvalid,
    input  logic            s1_rvalid,
    input  logic [DW-1:0]   s0_rdata,
    input  logic [DW-1:0]   s1_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dmem_demux12: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            sel_q, sel_d;
    logic            s_we_q, s_we_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [DW/8-1:0] s_be_q, s_be_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    // Only the latched target is ever listened to; the other one is masked out here.
    logic          tgt_gnt;
    logic          tgt_rvalid;
    logic [DW-1:0] tgt_rdata;

    assign tgt_gnt    = sel_q ? s1_gnt    : s0_gnt;
    assign tgt_rvalid = sel_q ? s1_rvalid : s0_rvalid;
    assign tgt_rdata  = sel_q ? s1_rdata  : s0_rdata;

`ifdef DMEM_DEMUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          waiting;

    assign waiting = (state_q == REQ) || (state_q == RESP);
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_be_d    = s_be_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (m_req) begin
                    s_we_d    = m_we;
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    s_be_d    = m_be;
                    sel_d     = (m_addr[AW-1:AW-4] == MMIO_NIBBLE);
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (tgt_gnt) begin
                    if (tgt_rvalid) begin
                        rdata_d = tgt_rdata;
                        state_d = DONE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (tgt_rvalid) begin
                    rdata_d = tgt_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DMEM_DEMUX_TIMEOUT_EN
        err_d = 1'b0;
        cnt_d = waiting ? cnt_q + CW'(1) : '0;
        // A response landing in the final cycle still wins over the timeout.
        if (waiting && (state_d != DONE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
            state_d = DONE;
            rdata_d = '0;
            err_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_be_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_be_q    <= s_be_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef DMEM_DEMUX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign m_err = err_q;
`else
    assign m_err = 1'b0;
`endif

    // Grant is withheld during reset so a request is never accepted into an aborting cycle.
    assign m_gnt    = m_req && (state_q == IDLE) && !rst;
    assign m_rvalid = (state_q == DONE);
    assign m_rdata  = rdata_q;
    assign s0_req   = (state_q == REQ) && !sel_q;
    assign s1_req   = (state_q == REQ) && sel_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_be     = s_be_q;

endmodule

// File: tb/tb_dmem_demux12.sv
// Directed self-checking bench for dmem_demux12; the timeout scenario runs only when
// DMEM_DEMUX_TIMEOUT_EN is defined for the build.
module tb_dmem_demux12;

    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            m_req, m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_be;
    logic            m_gnt, m_rvalid, m_err;
    logic [DW-1:0]   m_rdata;
    logic            s0_req, s1_req, s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_be;
    logic            s0_gnt, s1_gnt, s0_rvalid, s1_rvalid;
    logic [DW-1:0]   s0_rdata, s1_rdata;

    always #5 clk = ~clk;

    dmem_demux12 #(
        .DW             (DW),
        .AW             (AW),
        .MMIO_NIBBLE    (4'h1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_gnt     (m_gnt),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_err     (m_err),
        .s0_req    (s0_req),
        .s1_req    (s1_req),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_be      (s_be),
        .s0_gnt    (s0_gnt),
        .s1_gnt    (s1_gnt),
        .s0_rvalid (s0_rvalid),
        .s1_rvalid (s1_rvalid),
        .s0_rdata  (s0_rdata),
        .s1_rdata  (s1_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
        s0_gnt = 1'b0; s1_gnt = 1'b0; s0_rvalid = 1'b0; s1_rvalid = 1'b0;
        s0_rdata = '0; s1_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE. The selected target grants at cycle 1+gnt_dly and answers
    // at cycle 1+gnt_dly+rsp_dly (cycle 0 = the m_gnt cycle). With junk set, the other target
    // asserts gnt/rvalid with all-ones data every cycle and the selected target strays in IDLE.
    task automatic run_txn(input string tag, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW/8-1:0] be,
                           input int gnt_dly, input int rsp_dly, input logic [DW-1:0] rdata,
                           input bit junk, input int exp_req_cyc, input int exp_rv_cyc,
                           input logic [DW-1:0] exp_rdata, input logic exp_err);
        int   g, r, last;
        int   gnt_cnt, sel_req_cyc, oth_req_cyc, rv_cnt, rv_cyc, overlap;
        logic tgt, sel_gnt, sel_rv;
        logic [DW-1:0] sel_rd, got_rdata;
        logic got_err;
        g = 1 + gnt_dly;
        r = g + rsp_dly;
        last = (exp_rv_cyc > r + 1) ? exp_rv_cyc + 1 : r + 2;
        if (last < r + 2) last = r + 2;
        tgt = (addr[AW-1:AW-4] == 4'h1);
        gnt_cnt = 0; sel_req_cyc = 0; oth_req_cyc = 0; rv_cnt = 0; rv_cyc = -1; overlap = 0;
        got_rdata = '0; got_err = 1'b0;
        for (int c = 0; c <= last; c++) begin
            m_req   = (c == 0);
            m_we    = (c == 0) ? we    : ~we;
            m_addr  = (c == 0) ? addr  : ~addr;
            m_wdata = (c == 0) ? wdata : ~wdata;
            m_be    = (c == 0) ? be    : ~be;
            sel_gnt = (c == g) || (junk && c == 0);
            sel_rv  = (c == r) || (junk && c == 0);
            sel_rd  = (c == r) ? rdata : 32'hFFFF_FFFF;
            s0_gnt    = tgt ? junk : sel_gnt;
            s0_rvalid = tgt ? junk : sel_rv;
            s0_rdata  = tgt ? 32'hFFFF_FFFF : sel_rd;
            s1_gnt    = tgt ? sel_gnt : junk;
            s1_rvalid = tgt ? sel_rv  : junk;
            s1_rdata  = tgt ? sel_rd  : 32'hFFFF_FFFF;
            @(negedge clk);
            gnt_cnt     += int'(m_gnt);
            sel_req_cyc += int'(tgt ? s1_req : s0_req);
            oth_req_cyc += int'(tgt ? s0_req : s1_req);
            if (s0_req && s1_req) overlap++;
            if (m_rvalid) begin
                rv_cnt++;
                rv_cyc    = c;
                got_rdata = m_rdata;
                got_err   = m_err;
            end
            if (c == 0) check({tag, " m_gnt@0"}, 64'(m_gnt), 64'(1));
            if (c == 1) begin
                check({tag, " s_we"},    64'(s_we),    64'(we));
                check({tag, " s_addr"},  64'(s_addr),  64'(addr));
                check({tag, " s_wdata"}, 64'(s_wdata), 64'(wdata));
                check({tag, " s_be"},    64'(s_be),    64'(be));
            end
            if (c == last) begin
                check({tag, " s_addr held"},  64'(s_addr),  64'(addr));
                check({tag, " m_rdata held"}, 64'(m_rdata), 64'(exp_rdata));
            end
            next_cycle();
        end
        idle_inputs();
        check({tag, " gnt count"},     64'(gnt_cnt),     64'(1));
        check({tag, " sel req cyc"},   64'(sel_req_cyc), 64'(exp_req_cyc));
        check({tag, " other req cyc"}, 64'(oth_req_cyc), 64'(0));
        check({tag, " req overlap"},   64'(overlap),     64'(0));
        check({tag, " rvalid count"},  64'(rv_cnt),      64'(1));
        check({tag, " rvalid cycle"},  64'(rv_cyc),      64'(exp_rv_cyc));
        check({tag, " m_rdata"},       64'(got_rdata),   64'(exp_rdata));
        check({tag, " m_err"},         64'(got_err),     64'(exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " m_gnt"},    64'(m_gnt),    64'(0));
        check({tag, " m_rvalid"}, 64'(m_rvalid), 64'(0));
        check({tag, " m_rdata"},  64'(m_rdata),  64'(0));
        check({tag, " m_err"},    64'(m_err),    64'(0));
        check({tag, " s0_req"},   64'(s0_req),   64'(0));
        check({tag, " s1_req"},   64'(s1_req),   64'(0));
        check({tag, " s_payload"}, {s_we, s_addr, s_be, 27'(s_wdata)}, 64'(0));
        check({tag, " s_wdata"},  64'(s_wdata),  64'(0));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        next_cycle();

        // zero-wait load from RAM
        run_txn("ld_s0", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D,
                1'b0, 1, 2, 32'hCAFE_F00D, 1'b0);

        // byte store to MMIO with a slow grant and a slow response
        run_txn("st_s1", 1'b1, 32'h1000_0004, 32'h0000_00A5, 4'b0001, 3, 2, 32'h5A5A_0000,
                1'b0, 4, 7, 32'h5A5A_0000, 1'b0);

        // back-to-back, m_req held: target 0 then target 1
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0100; m_be = 4'hF;
        @(negedge clk);
        check("b2b c0 m_gnt", 64'(m_gnt), 64'(1));
        next_cycle();
        m_addr = 32'h1000_0008;
        s0_gnt = 1'b1; s0_rvalid = 1'b1; s0_rdata = 32'h1111_1111;
        @(negedge clk);
        check("b2b c1 m_gnt", 64'(m_gnt), 64'(0));
        check("b2b c1 reqs", {s0_req, s1_req}, 64'(2'b10));
        next_cycle();
        s0_gnt = 1'b0; s0_rvalid = 1'b0;
        @(negedge clk);
        check("b2b c2 m_gnt", 64'(m_gnt), 64'(0));
        check("b2b c2 rvalid", 64'(m_rvalid), 64'(1));
        check("b2b c2 rdata", 64'(m_rdata), 64'(32'h1111_1111));
        check("b2b c2 reqs", {s0_req, s1_req}, 64'(0));
        next_cycle();
        @(negedge clk);
        check("b2b c3 m_gnt", 64'(m_gnt), 64'(1));
        check("b2b c3 rvalid", 64'(m_rvalid), 64'(0));
        next_cycle();
        m_req = 1'b0;
        s1_gnt = 1'b1; s1_rvalid = 1'b1; s1_rdata = 32'h2222_2222;
        @(negedge clk);
        check("b2b c4 reqs", {s0_req, s1_req}, 64'(2'b01));
        check("b2b c4 s_addr", 64'(s_addr), 64'(32'h1000_0008));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("b2b c5 rvalid", 64'(m_rvalid), 64'(1));
        check("b2b c5 rdata", 64'(m_rdata), 64'(32'h2222_2222));
        next_cycle();

        // non-selected target chatter during a target-0 load
        run_txn("junk_s1", 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1, 2, 32'h1234_5678,
                1'b1, 2, 5, 32'h1234_5678, 1'b0);

        // load from MMIO, leaves nonzero m_rdata ahead of the reset test
        run_txn("ld_s1", 1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, 1, 32'h8765_4321,
                1'b0, 1, 3, 32'h8765_4321, 1'b0);

        // reset while waiting in RESP
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0030; m_be = 4'hF;
        @(negedge clk);
        next_cycle();
        m_req = 1'b0; m_addr = '0; m_be = '0;
        s0_gnt = 1'b1;
        @(negedge clk);
        check("rst s0_req in REQ", 64'(s0_req), 64'(1));
        next_cycle();
        s0_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst RESP rvalid", 64'(m_rvalid), 64'(0));
        next_cycle();
        rst = 1'b0;
        s0_rvalid = 1'b1; s0_rdata = 32'hDEAD_DEAD;
        @(negedge clk);
        check_all_zero("after rst");
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("late rvalid ignored", 64'(m_rvalid), 64'(0));
        check("late rdata ignored", 64'(m_rdata), 64'(0));
        next_cycle();
        run_txn("post_rst", 1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 1, 32'h0BAD_BEEF,
                1'b0, 3, 5, 32'h0BAD_BEEF, 1'b0);

`ifdef DMEM_DEMUX_TIMEOUT_EN
        // s0 grants only long after the timeout fired; that late grant/rvalid must be ignored
        run_txn("timeout", 1'b0, 32'h0000_0050, 32'h0, 4'hF, 30, 0, 32'h7777_7777,
                1'b0, 16, 17, 32'h0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
